// File: rtl/inst_fetch_q_if.sv
// Fetch-stage signal bundle: ROM address/data, branch redirect and the decode-facing instruction queue head.
// master = fetch stage, slave = ROM/decode/control side.
interface inst_fetch_q_if #(
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH + 1);

   logic          fetch_en;
   logic          redirect;
   logic [7:0]    redirect_pc;
   logic [7:0]    rom_addr;
   logic [63:0]   rom_data;
   logic          inst_valid;
   logic [31:0]   inst;
   logic [7:0]    inst_pc;
   logic          inst_ready;
   logic [CW-1:0] q_count;

   modport master (
      input  fetch_en, redirect, redirect_pc, rom_data, inst_ready,
      output rom_addr, inst_valid, inst, inst_pc, q_count
   );

   modport slave (
      output fetch_en, redirect, redirect_pc, rom_data, inst_ready,
      input  rom_addr, inst_valid, inst, inst_pc, q_count
   );
endinterface

// File: rtl/inst_fetch_q.sv
// Fetch PC + ROM word splitter feeding a DEPTH-entry instruction queue; fetched instr visible next cycle.
// Fetch stalls while free slots (registered count, pops not credited) < instrs left in the word; redirect flushes.
module inst_fetch_q #(
   parameter logic [7:0] RESET_PC = 8'h00,
   parameter int         DEPTH    = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   inst_fetch_q_if.master bus
);
   localparam int              PW      = $clog2(DEPTH);
   localparam int              CW      = $clog2(DEPTH + 1);
   localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
   localparam logic [7:0]      PC_RST  = RESET_PC & 8'hFC;

   logic [7:0]    pc_q, pc_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   inst_mem_q [DEPTH];
   logic [31:0]   inst_mem_d [DEPTH];
   logic [7:0]    pc_mem_q   [DEPTH];
   logic [7:0]    pc_mem_d   [DEPTH];

   logic [CW-1:0] need;
   logic [CW-1:0] free;
   logic [CW-1:0] n_push;
   logic [CW-1:0] n_pop;
   logic [PW-1:0] wr_ptr_p1;
   logic          fire;
   logic          pop;
   logic          head_vld;

   // Word-aligned PC consumes both halves; a PC at +4 only has the low half left.
   always_comb begin
      need      = pc_q[2] ? CW'(1) : CW'(2);
      free      = DEPTH_C - count_q;
      head_vld  = (count_q != '0);
      fire      = bus.fetch_en & ~bus.redirect & (free >= need);
      pop       = head_vld & bus.inst_ready & ~bus.redirect;
      wr_ptr_p1 = wr_ptr_q + PW'(1);
   end

   always_comb begin
      pc_d       = pc_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      inst_mem_d = inst_mem_q;
      pc_mem_d   = pc_mem_q;
      n_push     = '0;
      n_pop      = '0;

      if (bus.redirect) begin
         pc_d     = bus.redirect_pc & 8'hFC;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (fire) begin
            if (pc_q[2]) begin
               inst_mem_d[wr_ptr_q] = bus.rom_data[31:0];
               pc_mem_d[wr_ptr_q]   = pc_q;
               wr_ptr_d             = wr_ptr_p1;
               pc_d                 = pc_q + 8'd4;
               n_push               = CW'(1);
            end else begin
               inst_mem_d[wr_ptr_q]  = bus.rom_data[63:32];
               pc_mem_d[wr_ptr_q]    = pc_q;
               inst_mem_d[wr_ptr_p1] = bus.rom_data[31:0];
               pc_mem_d[wr_ptr_p1]   = pc_q + 8'd4;
               wr_ptr_d              = wr_ptr_p1 + PW'(1);
               pc_d                  = pc_q + 8'd8;
               n_push                = CW'(2);
            end
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            n_pop    = CW'(1);
         end
         count_d = count_q + n_push - n_pop;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q     <= PC_RST;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            inst_mem_q[i] <= '0;
            pc_mem_q[i]   <= '0;
         end
      end else begin
         pc_q       <= pc_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         inst_mem_q <= inst_mem_d;
         pc_mem_q   <= pc_mem_d;
      end
   end

   assign bus.rom_addr   = {pc_q[7:3], 3'b000};
   assign bus.inst_valid = head_vld;
   assign bus.inst       = head_vld ? inst_mem_q[rd_ptr_q] : 32'h0;
   assign bus.inst_pc    = head_vld ? pc_mem_q[rd_ptr_q] : 8'h0;
   assign bus.q_count    = count_q;

   // Occupancy must never exceed capacity and must agree with the pointer distance.
   a_count_bound : assert property (@(posedge clk) disable iff (!rst_n) count_q <= DEPTH_C);
   a_ptr_match   : assert property (@(posedge clk) disable iff (!rst_n)
                                    (wr_ptr_q - rd_ptr_q) == count_q[PW-1:0]);
endmodule

// File: tb/tb_inst_fetch_q.sv
// Directed bench for inst_fetch_q: reset, streaming, backpressure, redirect, PC wrap and async reset.
module tb_inst_fetch_q;
   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   inst_fetch_q_if #(.DEPTH(4)) bus ();

   inst_fetch_q #(.RESET_PC(8'h00), .DEPTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ROM: two fixed program words, elsewhere each instr is 32'hC0DE00xx with xx = its own byte address.
   function automatic logic [63:0] rom_word(input logic [7:0] a);
      logic [7:0] a4;
      a4 = a + 8'd4;
      case (a)
         8'h00:   rom_word = 64'hE3A00001_E3A01002;
         8'h08:   rom_word = 64'hE0802001_EAFFFFFE;
         default: rom_word = {24'hC0DE00, a, 24'hC0DE00, a4};
      endcase
   endfunction

   assign bus.rom_data = rom_word(bus.rom_addr);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      bus.fetch_en    = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 8'h00;
      bus.inst_ready  = 1'b0;
      rst_n           = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Assumes inst_ready=1; waits a bounded number of cycles for a head, checks it, lets it pop.
   task automatic pop_expect(input string tag, input logic [7:0] epc, input logic [31:0] ei);
      int w;
      w = 0;
      while (!bus.inst_valid && w < 20) begin
         step();
         w++;
      end
      if (!bus.inst_valid) begin
         chk({tag, "_vld"}, 64'(bus.inst_valid), 64'd1);
      end else begin
         chk({tag, "_pc"}, 64'(bus.inst_pc), 64'(epc));
         chk({tag, "_inst"}, 64'(bus.inst), 64'(ei));
         step();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      errors          = 0;
      checks          = 0;
      rst_n           = 1'b0;
      bus.fetch_en    = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 8'h00;
      bus.inst_ready  = 1'b0;

      // 1: reset state, then hold with fetch disabled
      #12;
      chk("rst_rom_addr", 64'(bus.rom_addr), 64'h00);
      chk("rst_valid", 64'(bus.inst_valid), 64'd0);
      chk("rst_count", 64'(bus.q_count), 64'd0);
      chk("rst_inst", 64'(bus.inst), 64'h0);
      chk("rst_inst_pc", 64'(bus.inst_pc), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      step();
      chk("hold_count", 64'(bus.q_count), 64'd0);
      chk("hold_rom_addr", 64'(bus.rom_addr), 64'h00);
      chk("hold_valid", 64'(bus.inst_valid), 64'd0);

      // 2: streaming with decode always ready
      bus.inst_ready = 1'b1;
      bus.fetch_en   = 1'b1;
      pop_expect("s0", 8'h00, 32'hE3A00001);
      pop_expect("s1", 8'h04, 32'hE3A01002);
      pop_expect("s2", 8'h08, 32'hE0802001);
      pop_expect("s3", 8'h0C, 32'hEAFFFFFE);

      // 3: backpressure from reset
      do_reset();
      bus.fetch_en = 1'b1;
      step();
      chk("bp_count1", 64'(bus.q_count), 64'd2);
      chk("bp_lat_valid", 64'(bus.inst_valid), 64'd1);
      chk("bp_lat_pc", 64'(bus.inst_pc), 64'h00);
      chk("bp_lat_inst", 64'(bus.inst), 64'hE3A00001);
      chk("bp_rom_addr1", 64'(bus.rom_addr), 64'h08);
      step();
      chk("bp_count2", 64'(bus.q_count), 64'd4);
      chk("bp_rom_addr2", 64'(bus.rom_addr), 64'h10);
      step();
      chk("bp_full_count", 64'(bus.q_count), 64'd4);
      chk("bp_full_rom_addr", 64'(bus.rom_addr), 64'h10);
      bus.inst_ready = 1'b1;
      step();
      chk("bp_pop1_count", 64'(bus.q_count), 64'd3);
      chk("bp_pop1_rom_addr", 64'(bus.rom_addr), 64'h10);
      chk("bp_pop1_head", 64'(bus.inst_pc), 64'h04);
      step();
      chk("bp_pop2_count", 64'(bus.q_count), 64'd2);
      chk("bp_pop2_rom_addr", 64'(bus.rom_addr), 64'h10);
      chk("bp_pop2_head", 64'(bus.inst), 64'hE0802001);
      bus.inst_ready = 1'b0;
      step();
      chk("bp_refill_count", 64'(bus.q_count), 64'd4);
      chk("bp_refill_rom_addr", 64'(bus.rom_addr), 64'h18);

      // 4: redirect to a misaligned target with three entries queued
      bus.inst_ready = 1'b1;
      step();
      bus.inst_ready = 1'b0;
      chk("rd_pre_count", 64'(bus.q_count), 64'd3);
      chk("rd_pre_head", 64'(bus.inst_pc), 64'h0C);
      bus.redirect    = 1'b1;
      bus.redirect_pc = 8'h26;
      bus.inst_ready  = 1'b1;
      step();
      bus.redirect   = 1'b0;
      bus.inst_ready = 1'b0;
      chk("rd_count", 64'(bus.q_count), 64'd0);
      chk("rd_valid", 64'(bus.inst_valid), 64'd0);
      chk("rd_empty_inst", 64'(bus.inst), 64'h0);
      chk("rd_rom_addr", 64'(bus.rom_addr), 64'h20);
      step();
      chk("rd_push_count", 64'(bus.q_count), 64'd1);
      chk("rd_push_pc", 64'(bus.inst_pc), 64'h24);
      chk("rd_push_inst", 64'(bus.inst), 64'hC0DE0024);
      chk("rd_next_rom_addr", 64'(bus.rom_addr), 64'h28);

      // 5: redirect with fetch disabled, then PC wrap past 0xFF
      bus.fetch_en    = 1'b0;
      bus.redirect    = 1'b1;
      bus.redirect_pc = 8'hF8;
      step();
      bus.redirect = 1'b0;
      chk("wr_count", 64'(bus.q_count), 64'd0);
      chk("wr_rom_addr", 64'(bus.rom_addr), 64'hF8);
      bus.fetch_en   = 1'b1;
      bus.inst_ready = 1'b1;
      pop_expect("w0", 8'hF8, 32'hC0DE00F8);
      pop_expect("w1", 8'hFC, 32'hC0DE00FC);
      pop_expect("w2", 8'h00, 32'hE3A00001);
      pop_expect("w3", 8'h04, 32'hE3A01002);

      // 6: asynchronous reset between clock edges
      do_reset();
      bus.fetch_en = 1'b1;
      step();
      bus.inst_ready = 1'b1;
      step();
      bus.fetch_en   = 1'b0;
      bus.inst_ready = 1'b0;
      chk("ar_pre_count", 64'(bus.q_count), 64'd3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_count", 64'(bus.q_count), 64'd0);
      chk("ar_valid", 64'(bus.inst_valid), 64'd0);
      chk("ar_rom_addr", 64'(bus.rom_addr), 64'h00);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("ar_post_count", 64'(bus.q_count), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
